sine_pwm_driver: RTL

//  Sequential partner of the sine lookup. Drives angle_out (table index 0..TABLE_LEN-1)

---
 rtl/sine_pwm_driver_if.sv | 24 ++
 rtl/sine_pwm_driver.sv | 69 ++++++
 2 files changed

// File: rtl/sine_pwm_driver_if.sv
// sine_pwm_driver_if: run control, lookup exchange and PWM outputs of sine_pwm_driver
//   enable        run request (master -> slave)
//   duty_in       lookup sample for angle_out (master -> slave)
//   angle_out     table index presented to the lookup (slave -> master)
//   pwm_out       registered PWM output (slave -> master)
//   period_start  first cycle of every RUN period (slave -> master)
//   busy          slave is in RUN (slave -> master)
//   pwm_n_out     complementary dead-banded output, only with SINE_PWM_COMPLEMENT_EN
interface sine_pwm_driver_if;
    logic       enable;
    logic [7:0] duty_in;
    logic [7:0] angle_out;
    logic       pwm_out;
    logic       period_start;
    logic       busy;
`ifdef SINE_PWM_COMPLEMENT_EN
    logic       pwm_n_out;
    modport master (output enable, duty_in, input angle_out, pwm_out, period_start, busy, pwm_n_out);
    modport slave (input enable, duty_in, output angle_out, pwm_out, period_start, busy, pwm_n_out);
`else
    modport master (output enable, duty_in, input angle_out, pwm_out, period_start, busy);
    modport slave (input enable, duty_in, output angle_out, pwm_out, period_start, busy);
`endif
endinterface

// File: rtl/sine_pwm_driver.sv
// sine_pwm_driver: steps a sine-table index and turns each looked-up sample into one PWM period
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sine_pwm_driver_if.slave (enable, duty_in in; angle_out, pwm_out, period_start, busy,
//          and pwm_n_out when SINE_PWM_COMPLEMENT_EN is defined, out)
// Define SINE_PWM_COMPLEMENT_EN to add the dead-banded complementary output.
module sine_pwm_driver #(
    parameter int PERIOD          = 100,
    parameter int TABLE_LEN       = 47,
    parameter int STEPS_PER_ANGLE = 1,
    parameter int DEAD            = 2
) (
    input logic              clk,
    input logic              rst_n,
    sine_pwm_driver_if.slave bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;
    localparam logic [7:0] LAST     = 8'(PERIOD - 1);
    localparam logic [7:0] TOP      = 8'(PERIOD);
    localparam logic [7:0] ANG_LAST = 8'(TABLE_LEN - 1);
    localparam logic [7:0] STEPS    = 8'(STEPS_PER_ANGLE);
    logic [0:0] state;
    logic [7:0] cnt, duty_reg, step_cnt, step_nxt, duty_clamp;
    logic       run, wrap, load, step_done;
    // load marks a boundary edge that stays in (or enters) RUN; a wrap with enable low
    // returns to IDLE without touching angle or step count
    always_comb begin
        run        = state == RUN;
        wrap       = run && cnt == LAST;
        load       = bus.enable && (!run || wrap);
        duty_clamp = bus.duty_in > TOP ? TOP : bus.duty_in;
        step_nxt   = step_cnt + 8'd1;
        step_done  = step_nxt == STEPS;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            duty_reg         <= 8'd0;
            step_cnt         <= 8'd0;
            bus.angle_out    <= 8'd0;
            bus.pwm_out      <= 1'b0;
            bus.period_start <= 1'b0;
            bus.busy         <= 1'b0;
`ifdef SINE_PWM_COMPLEMENT_EN
            bus.pwm_n_out    <= 1'b0;
`endif
        end else begin
            state <= load ? RUN : (wrap ? IDLE : state);
            cnt   <= (!run || wrap) ? 8'd0 : cnt + 8'd1;
            if (load) begin
                duty_reg <= duty_clamp;
                step_cnt <= step_done ? 8'd0 : step_nxt;
                if (step_done)
                    bus.angle_out <= bus.angle_out == ANG_LAST ? 8'd0 : bus.angle_out + 8'd1;
            end
            // outputs describe the cycle whose cnt is current, one clock later
            bus.pwm_out      <= run && cnt < duty_reg;
            bus.period_start <= run && cnt == 8'd0;
            bus.busy         <= run;
`ifdef SINE_PWM_COMPLEMENT_EN
            // 9-bit sum so duty_reg+DEAD cannot wrap past the period
            bus.pwm_n_out    <= run && {1'b0, cnt} >= {1'b0, duty_reg} + 9'(DEAD)
                                    && cnt <= 8'(PERIOD - 1 - DEAD);
`endif
        end
    end
endmodule
